// File: rtl/vga_bounce_render_pkg.sv
// Shared VGA constants and 3-3-2 colour types for the bounce renderer.
// Supplies default resolution, colour field widths and axis direction type.
package vga_bounce_render_pkg;

    localparam int VGA_RES_H = 1920;
    localparam int VGA_RES_V = 1080;
    localparam int VGA_R_W   = 3;
    localparam int VGA_G_W   = 3;
    localparam int VGA_B_W   = 2;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef struct packed {
        logic [VGA_R_W-1:0] r;
        logic [VGA_G_W-1:0] g;
        logic [VGA_B_W-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = '{r: '1, g: '1, b: '1};
    localparam rgb_t RGB_BLACK = '{r: '0, g: '0, b: '0};

endpackage

// File: rtl/vga_bounce_render_axis.sv
// One motion axis of the bouncing box: position, direction, step and clamp.
// Ports: clk_i, rst_ni, tick_i (frame update), freeze_i, speed_i (step-1), pos_o.
module vga_bounce_axis
    import vga_bounce_render_pkg::*;
#(
    parameter int RES   = 1920,
    parameter int BOX   = 64,
    parameter int CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             freeze_i,
    input  logic [2:0]       speed_i,
    output logic [CNT_W-1:0] pos_o
);

    localparam int LIM = RES - BOX;

    logic [CNT_W-1:0] pos_q, pos_d;
    dir_e             dir_q, dir_d;
    logic [CNT_W:0]   step;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   lim_w;

    // One extra bit keeps pos + step from wrapping near the far edge.
    assign step  = {{(CNT_W-2){1'b0}}, speed_i} + (CNT_W+1)'(1);
    assign sum   = {1'b0, pos_q} + step;
    assign lim_w = (CNT_W+1)'(LIM);

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick_i && !freeze_i) begin
            if (dir_q == DIR_POS) begin
                if (sum >= lim_w) begin
                    pos_d = lim_w[CNT_W-1:0];
                    dir_d = DIR_NEG;
                end else begin
                    pos_d = sum[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, pos_q} <= step) begin
                    pos_d = '0;
                    dir_d = DIR_POS;
                end else begin
                    pos_d = pos_q - step[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q <= '0;
            dir_q <= DIR_POS;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/vga_bounce_render.sv
// Two-stage pixel colour pipe drawing a bouncing box over a checker background.
// In: PIXEL_CLK, RST_N, cnt_x/cnt_y, active_in, hsync_in, vsync_in, speed,
// color, freeze. Out: vgaRed/vgaGreen/vgaBlue, Hsync, Vsync, frame_tick.
// Optional white screen border when VGA_BORDER_EN is defined.
module vga_bounce_render
    import vga_bounce_render_pkg::*;
#(
    parameter int RES_H = VGA_RES_H,
    parameter int RES_V = VGA_RES_V,
    parameter int BOX_W = 64,
    parameter int BOX_H = 64,
    parameter int CNT_W = 13
) (
    input  logic             PIXEL_CLK,
    input  logic             RST_N,
    input  logic [CNT_W-1:0] cnt_x,
    input  logic [CNT_W-1:0] cnt_y,
    input  logic             active_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [2:0]       speed,
    input  logic [7:0]       color,
    input  logic             freeze,
    output logic [2:0]       vgaRed,
    output logic [2:0]       vgaGreen,
    output logic [1:0]       vgaBlue,
    output logic             Hsync,
    output logic             Vsync,
    output logic             frame_tick
);

    logic [CNT_W-1:0] box_x;
    logic [CNT_W-1:0] box_y;

    // Frame edge detection
    logic vs_prev_q;
    logic primed_q;
    logic tick_q;
    logic rise;

    // The first clock after reset only loads vs_prev, so a vsync that is
    // already high when reset releases is not mistaken for an edge.
    assign rise = primed_q & vsync_in & ~vs_prev_q;

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            vs_prev_q <= 1'b0;
            primed_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            primed_q  <= 1'b1;
            tick_q    <= rise;
        end
    end

    assign frame_tick = tick_q;

    vga_bounce_axis #(
        .RES   (RES_H),
        .BOX   (BOX_W),
        .CNT_W (CNT_W)
    ) u_axis_x (
        .clk_i    (PIXEL_CLK),
        .rst_ni   (RST_N),
        .tick_i   (tick_q),
        .freeze_i (freeze),
        .speed_i  (speed),
        .pos_o    (box_x)
    );

    vga_bounce_axis #(
        .RES   (RES_V),
        .BOX   (BOX_H),
        .CNT_W (CNT_W)
    ) u_axis_y (
        .clk_i    (PIXEL_CLK),
        .rst_ni   (RST_N),
        .tick_i   (tick_q),
        .freeze_i (freeze),
        .speed_i  (speed),
        .pos_o    (box_y)
    );

    // Stage 1: box hit test and checker
    logic [CNT_W:0] x_end;
    logic [CNT_W:0] y_end;
    logic           in_box;
    logic           bg;

    assign x_end  = {1'b0, box_x} + (CNT_W+1)'(BOX_W);
    assign y_end  = {1'b0, box_y} + (CNT_W+1)'(BOX_H);
    assign in_box = (cnt_x >= box_x) && ({1'b0, cnt_x} < x_end)
                 && (cnt_y >= box_y) && ({1'b0, cnt_y} < y_end);
    assign bg     = cnt_x[5] ^ cnt_y[5];

    logic act1_q, hs1_q, vs1_q, box1_q, bg1_q;

`ifdef VGA_BORDER_EN
    logic on_edge;
    logic edge1_q;

    assign on_edge = (cnt_x == '0) || (cnt_x == CNT_W'(RES_H-1))
                  || (cnt_y == '0) || (cnt_y == CNT_W'(RES_V-1));

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            edge1_q <= 1'b0;
        end else begin
            edge1_q <= on_edge;
        end
    end
`endif

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            act1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            box1_q <= 1'b0;
            bg1_q  <= 1'b0;
        end else begin
            act1_q <= active_in;
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
            box1_q <= in_box;
            bg1_q  <= bg;
        end
    end

    // Stage 2: colour mux
    rgb_t rgb_d, rgb_q;
    logic hs2_q, vs2_q;

    always_comb begin
        rgb_d = RGB_BLACK;
        if (act1_q) begin
`ifdef VGA_BORDER_EN
            if (edge1_q) rgb_d = RGB_WHITE;
            else
`endif
            if (box1_q) rgb_d = rgb_t'(color);
            else rgb_d = '{r: '0, g: '0, b: {1'b0, bg1_q}};
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rgb_q <= RGB_BLACK;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign vgaRed   = rgb_q.r;
    assign vgaGreen = rgb_q.g;
    assign vgaBlue  = rgb_q.b;
    assign Hsync    = hs2_q;
    assign Vsync    = vs2_q;

endmodule

// File: tb/tb_vga_bounce_render.sv
// Self-checking bench for vga_bounce_render: vector table, sync delay,
// bounce motion against a frame-level model, freeze, back-to-back vsync.
module tb_vga_bounce_render;

    localparam int RH = 1920;
    localparam int RV = 1080;
    localparam int BW = 64;
    localparam int BH = 64;
    localparam int LX = RH - BW;
    localparam int LY = RV - BH;

    logic        PIXEL_CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [12:0] cnt_x = '0;
    logic [12:0] cnt_y = '0;
    logic        active_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [2:0]  speed = '0;
    logic [7:0]  color = '0;
    logic        freeze = 1'b0;
    logic [2:0]  vgaRed, vgaGreen;
    logic [1:0]  vgaBlue;
    logic        Hsync, Vsync, frame_tick;

    vga_bounce_render dut (
        .PIXEL_CLK  (PIXEL_CLK),
        .RST_N      (RST_N),
        .cnt_x      (cnt_x),
        .cnt_y      (cnt_y),
        .active_in  (active_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .speed      (speed),
        .color      (color),
        .freeze     (freeze),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .frame_tick (frame_tick)
    );

    always #5 PIXEL_CLK = ~PIXEL_CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Frame-level reference model of the box
    int mx, my;
    bit mxneg, myneg;

    typedef struct {
        int         x;
        int         y;
        bit         act;
        logic [7:0] col;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge PIXEL_CLK);
        #1;
    endtask

    function automatic int rgb_now();
        return int'({vgaRed, vgaGreen, vgaBlue});
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mxneg = 0; myneg = 0;
    endtask

    task automatic axis_move(inout int pos, inout bit neg, input int s, input int lim);
        if (!neg) begin
            if (pos + s >= lim) begin pos = lim; neg = 1; end
            else pos = pos + s;
        end else begin
            if (pos <= s) begin pos = 0; neg = 0; end
            else pos = pos - s;
        end
    endtask

    task automatic model_frame(input int spd, input bit frz);
        if (!frz) begin
            axis_move(mx, mxneg, spd + 1, LX);
            axis_move(my, myneg, spd + 1, LY);
        end
    endtask

    function automatic int ref_rgb(input int x, input int y, input bit act, input logic [7:0] col);
        bit inb;
        bit bgb;
        if (!act) return 0;
`ifdef VGA_BORDER_EN
        if (x == 0 || x == RH - 1 || y == 0 || y == RV - 1) return 8'hFF;
`endif
        inb = (x >= mx) && (x < mx + BW) && (y >= my) && (y < my + BH);
        if (inb) return int'(col);
        bgb = ((x >> 5) & 1) != ((y >> 5) & 1);
        return bgb ? 1 : 0;
    endfunction

    task automatic pixel(input int x, input int y, input bit act, input logic [7:0] col);
        cnt_x = 13'(x);
        cnt_y = 13'(y);
        active_in = act;
        color = col;
        step();
        step();
    endtask

    task automatic apply_reset(input bit vs_level);
        RST_N = 1'b0;
        vsync_in = vs_level;
        #1;
        check("reset_rgb", rgb_now(), 0);
        check("reset_hsync", int'(Hsync), 0);
        check("reset_vsync", int'(Vsync), 0);
        check("reset_tick", int'(frame_tick), 0);
        check("reset_box_x", int'(dut.box_x), 0);
        check("reset_box_y", int'(dut.box_y), 0);
        model_reset();
        step();
        RST_N = 1'b1;
    endtask

    // One vsync pulse; checks the tick and the resulting position.
    task automatic do_frame(input int spd, input bit frz);
        speed = 3'(spd);
        freeze = frz;
        vsync_in = 1'b1;
        step();
        check("frame_tick_hi", int'(frame_tick), 1);
        vsync_in = 1'b0;
        step();
        check("frame_tick_lo", int'(frame_tick), 0);
        model_frame(spd, frz);
        check("box_x", int'(dut.box_x), mx);
        check("box_y", int'(dut.box_y), my);
    endtask

    initial begin
        bit hs_h[64];
        bit vs_h[64];
        int ticks;
        int maxx;
        int x, y;
        logic [7:0] c;

        vecs[0] = '{x: 10,   y: 10,   act: 1, col: 8'hE0, exp: 8'hE0};
        vecs[1] = '{x: 96,   y: 0,    act: 1, col: 8'hE0, exp: 8'h01};
        vecs[2] = '{x: 100,  y: 100,  act: 1, col: 8'h1C, exp: 8'h00};
        vecs[3] = '{x: 64,   y: 64,   act: 1, col: 8'hFF, exp: 8'h00};
        vecs[4] = '{x: 63,   y: 63,   act: 1, col: 8'h1C, exp: 8'h1C};
        vecs[5] = '{x: 10,   y: 10,   act: 0, col: 8'hFF, exp: 8'h00};
        vecs[8] = '{x: 32,   y: 64,   act: 1, col: 8'hE0, exp: 8'h01};
`ifdef VGA_BORDER_EN
        vecs[6] = '{x: 0,    y: 0,    act: 1, col: 8'h03, exp: 8'hFF};
        vecs[7] = '{x: 1919, y: 500,  act: 1, col: 8'hE0, exp: 8'hFF};
        vecs[9] = '{x: 0,    y: 1079, act: 1, col: 8'hE0, exp: 8'hFF};
`else
        vecs[6] = '{x: 0,    y: 0,    act: 1, col: 8'h03, exp: 8'h03};
        vecs[7] = '{x: 1919, y: 500,  act: 1, col: 8'hE0, exp: 8'h00};
        vecs[9] = '{x: 0,    y: 1079, act: 1, col: 8'hE0, exp: 8'h01};
`endif

        apply_reset(1'b0);

        // Vector table with the box at the origin
        foreach (vecs[i]) begin
            pixel(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].col);
            check($sformatf("vec%0d_rgb", i), rgb_now(), int'(vecs[i].exp));
        end

        // Sync passthrough: exact 2-cycle delay, blank RGB
        active_in = 1'b0;
        freeze = 1'b1;
        for (int i = 0; i < 64; i++) begin
            hs_h[i] = 1'($urandom_range(0, 1));
            vs_h[i] = 1'($urandom_range(0, 1));
            hsync_in = hs_h[i];
            vsync_in = vs_h[i];
            step();
            if (i >= 1) begin
                check("hsync_delay", int'(Hsync), int'(hs_h[i-1]));
                check("vsync_delay", int'(Vsync), int'(vs_h[i-1]));
                check("blank_rgb", rgb_now(), 0);
            end
        end
        hsync_in = 1'b0;
        check("frozen_box_x", int'(dut.box_x), 0);
        check("frozen_box_y", int'(dut.box_y), 0);

        // Reset mid-frame with vsync held high: no spurious tick
        step();
        apply_reset(1'b1);
        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("no_tick_after_reset", ticks, 0);
        vsync_in = 1'b0;
        step();
        step();

        // 240 frames at speed 7 from the origin
        freeze = 1'b0;
        maxx = 0;
        for (int f = 0; f < 240; f++) begin
            do_frame(7, 1'b0);
            if (int'(dut.box_x) > maxx) maxx = int'(dut.box_x);
        end
        check("box_x_max", maxx, LX);
        pixel(mx, my, 1'b1, 8'h5A);
        check("corner_pixel", rgb_now(), ref_rgb(mx, my, 1'b1, 8'h5A));

        // Freeze across 5 edges
        ticks = 0;
        for (int f = 0; f < 5; f++) begin
            freeze = 1'b1;
            vsync_in = 1'b1;
            step();
            if (frame_tick) ticks++;
            vsync_in = 1'b0;
            step();
            if (frame_tick) ticks++;
        end
        check("freeze_ticks", ticks, 5);
        check("freeze_box_x", int'(dut.box_x), mx);
        check("freeze_box_y", int'(dut.box_y), my);

        // Random speeds/freeze with random pixel probes near the box
        for (int f = 0; f < 200; f++) begin
            do_frame(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            freeze = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                x = mx + int'($urandom_range(0, 100)) - 20;
                y = my + int'($urandom_range(0, 100)) - 20;
                if (x < 0) x = 0;
                if (x > RH - 1) x = RH - 1;
                if (y < 0) y = 0;
                if (y > RV - 1) y = RV - 1;
            end else begin
                x = int'($urandom_range(0, RH - 1));
                y = int'($urandom_range(0, RV - 1));
            end
            c = 8'($urandom);
            pixel(x, y, 1'($urandom_range(0, 7) != 0), c);
            check("rand_pixel", rgb_now(), ref_rgb(x, y, active_in, c));
        end

        // Back-to-back vsync edges: one tick per edge
        speed = 3'd2;
        freeze = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            vsync_in = (i % 2 == 0);
            step();
            if (frame_tick) ticks++;
        end
        vsync_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("b2b_ticks", ticks, 10);
        for (int i = 0; i < 10; i++) model_frame(2, 1'b0);
        check("b2b_box_x", int'(dut.box_x), mx);
        check("b2b_box_y", int'(dut.box_y), my);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
